// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bus initiator.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mmio_state_e;

  localparam int unsigned MMIO_DATA_W    = 32;
  localparam logic [15:0] MMIO_REGION_HI = 16'hFFFF;
  localparam int unsigned MMIO_MAX_DEV   = 64;

  // True when no more than one bit of vec is set (zero-hot or one-hot).
  function automatic logic at_most_one_hot(input logic [MMIO_MAX_DEV-1:0] vec);
    return (vec & (vec - 64'd1)) == '0;
  endfunction

endpackage

// File: rtl/mmio_dev_select.sv
// Combinational peripheral selection: hit detection, hit index and read-data mux.
module mmio_dev_select
  import mmio_pkg::*;
#(
  parameter int unsigned N_DEV = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_DEV-1:0]             dev_work,
  input  logic [MMIO_DATA_W*N_DEV-1:0] dev_read_data,
  input  logic [IDX_W-1:0]             sel,
  output logic                         hit_any,
  output logic                         hit_multi,
  output logic [IDX_W-1:0]             hit_idx,
  output logic [MMIO_DATA_W-1:0]       sel_rdata
);

  assign hit_any   = |dev_work;
  assign hit_multi = !at_most_one_hot(MMIO_MAX_DEV'(dev_work));

  // Lowest-numbered asserting slot; only meaningful when exactly one hits.
  always_comb begin
    logic found;
    found   = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (dev_work[i] && !found) begin
        hit_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end

  // Read data of the currently selected slot.
  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (IDX_W'(i) == sel) sel_rdata = dev_read_data[MMIO_DATA_W*i +: MMIO_DATA_W];
    end
  end

endmodule

// File: rtl/mmio_master.sv
// CPU-side MMIO bus initiator: one outstanding load/store, error on
// unmapped, overlapping or hung peripherals.
module mmio_master
  import mmio_pkg::*;
#(
  parameter int unsigned N_DEV   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [31:0]                  req_addr,
  input  logic [31:0]                  req_wdata,
  output logic                         resp_valid,
  output logic                         resp_err,
  output logic [31:0]                  resp_rdata,
  output logic                         mmio_read,
  output logic                         mmio_write,
  output logic [31:0]                  mmio_addr,
  output logic [31:0]                  mmio_write_data,
  input  logic [N_DEV-1:0]             dev_work,
  input  logic [N_DEV-1:0]             dev_done,
  input  logic [MMIO_DATA_W*N_DEV-1:0] dev_read_data
);

  localparam int unsigned IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  mmio_state_e             state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        sel;
  logic                    hit_any;
  logic                    hit_multi;
  logic [IDX_W-1:0]        hit_idx;
  logic [MMIO_DATA_W-1:0]  sel_rdata;
  logic                    sel_done;

  mmio_dev_select #(
    .N_DEV (N_DEV),
    .IDX_W (IDX_W)
  ) u_sel (
    .dev_work      (dev_work),
    .dev_read_data (dev_read_data),
    .sel           (sel),
    .hit_any       (hit_any),
    .hit_multi     (hit_multi),
    .hit_idx       (hit_idx),
    .sel_rdata     (sel_rdata)
  );

  assign sel_done = dev_done[sel];

  // Request/access/response FSM; every output is a flop so the bus and the
  // pipeline never see combinational paths through this block.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_err        <= 1'b0;
      resp_rdata      <= '0;
      mmio_read       <= 1'b0;
      mmio_write      <= 1'b0;
      mmio_addr       <= '0;
      mmio_write_data <= '0;
      cnt             <= '0;
      sel             <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mmio_addr       <= req_addr;
            mmio_write_data <= req_wdata;
            mmio_write      <= req_write;
            mmio_read       <= !req_write;
            cnt             <= '0;
            req_ready       <= 1'b0;
            state           <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            if (!hit_any || hit_multi) begin
              mmio_read  <= 1'b0;
              mmio_write <= 1'b0;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else begin
              sel <= hit_idx;
              cnt <= cnt + 1'b1;
            end
          end else if (sel_done) begin
            // Strobes fall on the same edge that samples done, so the
            // peripheral cannot see a second access.
            mmio_read  <= 1'b0;
            mmio_write <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= mmio_read ? sel_rdata : '0;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            mmio_read  <= 1'b0;
            mmio_write <= 1'b0;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          mmio_read  <= 1'b0;
          mmio_write <= 1'b0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_master.sv
// Directed bench for mmio_master with small behavioural peripheral models.
module tb_mmio_master;
  import mmio_pkg::*;

  localparam int unsigned N_DEV   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic                   sys_clk = 1'b0;
  logic                   rst_n   = 1'b0;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic                   req_write = 1'b0;
  logic [31:0]            req_addr  = '0;
  logic [31:0]            req_wdata = '0;
  logic                   resp_valid;
  logic                   resp_err;
  logic [31:0]            resp_rdata;
  logic                   mmio_read;
  logic                   mmio_write;
  logic [31:0]            mmio_addr;
  logic [31:0]            mmio_write_data;
  logic [N_DEV-1:0]       dev_work;
  logic [N_DEV-1:0]       dev_done;
  logic [32*N_DEV-1:0]    dev_read_data;

  int checks = 0;
  int errors = 0;

  mmio_master #(.N_DEV(N_DEV), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk         (sys_clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_err        (resp_err),
    .resp_rdata      (resp_rdata),
    .mmio_read       (mmio_read),
    .mmio_write      (mmio_write),
    .mmio_addr       (mmio_addr),
    .mmio_write_data (mmio_write_data),
    .dev_work        (dev_work),
    .dev_done        (dev_done),
    .dev_read_data   (dev_read_data)
  );

  always #5 sys_clk = ~sys_clk;

  // Peripheral models: slot0 LED reg, slot1 overlap window, slot2 hung, slot3 echo.
  logic        ovl_en     = 1'b0;
  logic [3:0]  done_q     = '0;
  logic [31:0] led_reg    = '0;
  int          led_writes = 0;
  int          s1_writes  = 0;
  logic        any_strobe;
  logic [3:0]  work;

  assign any_strobe = mmio_read | mmio_write;

  always_comb begin
    work    = '0;
    work[0] = any_strobe && (mmio_addr[31:16] == MMIO_REGION_HI) && (mmio_addr[15:7] == 9'h001);
    work[1] = any_strobe && ovl_en && (mmio_addr[31:4] == 28'hFFFF009);
    work[2] = any_strobe && (mmio_addr[31:8] == 24'hFFFF02);
    work[3] = any_strobe && (mmio_addr[31:8] == 24'hFFFF03);
  end

  assign dev_work      = work;
  assign dev_done      = {done_q[3], 1'b0, done_q[1], done_q[0]};
  assign dev_read_data = {{16'hA5A5, mmio_addr[15:0]}, 32'hDEAD_BEEF, 32'h1111_1111, led_reg};

  always @(posedge sys_clk) begin
    done_q <= work & ~done_q;
    if (done_q[0] && work[0] && mmio_write) begin
      led_reg    <= mmio_write_data;
      led_writes <= led_writes + 1;
    end
    if (done_q[1] && work[1] && mmio_write) s1_writes <= s1_writes + 1;
  end

  // Per-cycle trace of one transaction; bit j = sample after accept edge + j.
  logic [23:0] tr_rd, tr_wr, tr_rv, tr_rr;
  logic        cap_err;
  logic [31:0] cap_rdata;

  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int ncyc);
    @(negedge sys_clk);
    for (int w = 0; w < 40 && !req_ready; w++) @(negedge sys_clk);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_wait req_ready=%b required 1 within 40 cycles", req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(negedge sys_clk);
    req_valid = 1'b0;
    tr_rd = '0; tr_wr = '0; tr_rv = '0; tr_rr = '0;
    cap_err = 1'bx; cap_rdata = 'x;
    for (int j = 0; j < ncyc; j++) begin
      tr_rd[j] = mmio_read;
      tr_wr[j] = mmio_write;
      tr_rv[j] = resp_valid;
      tr_rr[j] = req_ready;
      if (resp_valid) begin
        cap_err   = resp_err;
        cap_rdata = resp_rdata;
      end
      if (j < ncyc - 1) @(negedge sys_clk);
    end
  endtask

  task automatic test_reset;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    checks++; if ({mmio_read, mmio_write} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b want 00", {mmio_read, mmio_write}); end
    checks++; if ({resp_err, resp_rdata} !== 33'd0) begin errors++; $display("FAIL rst_resp got err=%b data=%h want 0", resp_err, resp_rdata); end
    checks++; if ({mmio_addr, mmio_write_data} !== 64'd0) begin errors++; $display("FAIL rst_bus got %h/%h want 0", mmio_addr, mmio_write_data); end
  endtask

  task automatic test_store_led;
    int w0 = led_writes;
    do_req(1'b1, {MMIO_REGION_HI, 16'h0084}, 32'h1, 8);
    checks++; if (tr_wr[7:0] !== 8'b0000_0011) begin errors++; $display("FAIL st_write_strobe got %b want 00000011", tr_wr[7:0]); end
    checks++; if (tr_rd[7:0] !== 8'b0000_0000) begin errors++; $display("FAIL st_read_strobe got %b want 00000000", tr_rd[7:0]); end
    checks++; if (tr_rv[7:0] !== 8'b0000_0100) begin errors++; $display("FAIL st_resp_valid got %b want 00000100", tr_rv[7:0]); end
    checks++; if (tr_rr[7:0] !== 8'b1111_1000) begin errors++; $display("FAIL st_req_ready got %b want 11111000", tr_rr[7:0]); end
    checks++; if ({cap_err, cap_rdata} !== 33'd0) begin errors++; $display("FAIL st_resp got err=%b data=%h want 0/0", cap_err, cap_rdata); end
    checks++; if (led_reg !== 32'h1 || led_writes != w0 + 1) begin errors++; $display("FAIL st_led got reg=%h writes=%0d want 1 writes=%0d", led_reg, led_writes, w0 + 1); end
  endtask

  task automatic test_load_led;
    do_req(1'b0, {MMIO_REGION_HI, 16'h0084}, 32'h0, 8);
    checks++; if (tr_rd[7:0] !== 8'b0000_0011) begin errors++; $display("FAIL ld_read_strobe got %b want 00000011", tr_rd[7:0]); end
    checks++; if (tr_rv[7:0] !== 8'b0000_0100) begin errors++; $display("FAIL ld_resp_valid got %b want 00000100", tr_rv[7:0]); end
    checks++; if ({cap_err, cap_rdata} !== {1'b0, 32'h1}) begin errors++; $display("FAIL ld_resp got err=%b data=%h want 0/00000001", cap_err, cap_rdata); end
  endtask

  task automatic test_unmapped;
    do_req(1'b0, {MMIO_REGION_HI, 16'h1000}, 32'h0, 8);
    checks++; if (tr_rd[7:0] !== 8'b0000_0001) begin errors++; $display("FAIL um_read_strobe got %b want 00000001", tr_rd[7:0]); end
    checks++; if (tr_rv[7:0] !== 8'b0000_0010) begin errors++; $display("FAIL um_resp_valid got %b want 00000010", tr_rv[7:0]); end
    checks++; if (tr_rr[7:0] !== 8'b1111_1100) begin errors++; $display("FAIL um_req_ready got %b want 11111100", tr_rr[7:0]); end
    checks++; if ({cap_err, cap_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL um_resp got err=%b data=%h want 1/0", cap_err, cap_rdata); end
  endtask

  task automatic test_timeout;
    do_req(1'b0, {MMIO_REGION_HI, 16'h0210}, 32'h0, 24);
    checks++; if (tr_rd !== 24'h00FFFF) begin errors++; $display("FAIL to_read_strobe got %h want 00ffff", tr_rd); end
    checks++; if (tr_rv !== 24'h010000) begin errors++; $display("FAIL to_resp_valid got %h want 010000", tr_rv); end
    checks++; if (tr_rr !== 24'hFE0000) begin errors++; $display("FAIL to_req_ready got %h want fe0000", tr_rr); end
    checks++; if ({cap_err, cap_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL to_resp got err=%b data=%h want 1/0", cap_err, cap_rdata); end
  endtask

  task automatic test_overlap;
    int w0 = led_writes;
    int w1 = s1_writes;
    ovl_en = 1'b1;
    do_req(1'b1, {MMIO_REGION_HI, 16'h0090}, 32'h55, 8);
    ovl_en = 1'b0;
    checks++; if (tr_wr[7:0] !== 8'b0000_0001) begin errors++; $display("FAIL ov_write_strobe got %b want 00000001", tr_wr[7:0]); end
    checks++; if (tr_rv[7:0] !== 8'b0000_0010) begin errors++; $display("FAIL ov_resp_valid got %b want 00000010", tr_rv[7:0]); end
    checks++; if (cap_err !== 1'b1) begin errors++; $display("FAIL ov_resp_err got %b want 1", cap_err); end
    checks++; if (led_writes != w0 || s1_writes != w1 || led_reg !== 32'h1) begin errors++; $display("FAIL ov_no_write got led=%0d s1=%0d reg=%h want %0d %0d 00000001", led_writes, s1_writes, led_reg, w0, w1); end
  endtask

  task automatic test_back_to_back;
    int          accepts = 0;
    int          resps   = 0;
    logic        pre_acc;
    logic [31:0] exp_addr = '0;
    @(negedge sys_clk);
    req_write = 1'b0;
    for (int c = 0; c < 24; c++) begin
      req_valid = (c < 18);
      req_addr  = 32'hFFFF_0300 + 32'(c * 4);
      pre_acc   = req_valid && req_ready;
      @(negedge sys_clk);
      if (pre_acc) begin
        accepts++;
        exp_addr = 32'hFFFF_0300 + 32'(c * 4);
        checks++; if (mmio_addr !== exp_addr || mmio_read !== 1'b1) begin errors++; $display("FAIL b2b_accept c=%0d got addr=%h rd=%b want %h 1", c, mmio_addr, mmio_read, exp_addr); end
      end else if (accepts > 0) begin
        checks++; if (mmio_addr !== exp_addr) begin errors++; $display("FAIL b2b_hold c=%0d got addr=%h want %h", c, mmio_addr, exp_addr); end
      end
      if (resp_valid) begin
        resps++;
        checks++; if ({resp_err, resp_rdata} !== {1'b0, 16'hA5A5, exp_addr[15:0]}) begin errors++; $display("FAIL b2b_resp c=%0d got err=%b data=%h want 0/a5a5%h", c, resp_err, resp_rdata, exp_addr[15:0]); end
      end
    end
    checks++; if (accepts < 4 || resps != accepts) begin errors++; $display("FAIL b2b_count got accepts=%0d resps=%0d want >=4 and equal", accepts, resps); end
  endtask

  task automatic test_reset_mid_access;
    int w0;
    @(negedge sys_clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = {MMIO_REGION_HI, 16'h0200}; req_wdata = 32'h77;
    @(negedge sys_clk);
    req_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++; if (mmio_write !== 1'b1) begin errors++; $display("FAIL rm_pre_write got %b want 1", mmio_write); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mmio_read, mmio_write, resp_valid} !== 3'b000) begin errors++; $display("FAIL rm_strobes got %b want 000", {mmio_read, mmio_write, resp_valid}); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b want 1", req_ready); end
    @(negedge sys_clk);
    rst_n = 1'b1;
    w0 = led_writes;
    do_req(1'b1, {MMIO_REGION_HI, 16'h0088}, 32'h3, 8);
    checks++; if (tr_wr[7:0] !== 8'b0000_0011) begin errors++; $display("FAIL rm_write_strobe got %b want 00000011", tr_wr[7:0]); end
    checks++; if (tr_rv[7:0] !== 8'b0000_0100 || cap_err !== 1'b0) begin errors++; $display("FAIL rm_resp got rv=%b err=%b want 00000100 0", tr_rv[7:0], cap_err); end
    checks++; if (led_reg !== 32'h3 || led_writes != w0 + 1) begin errors++; $display("FAIL rm_led got reg=%h writes=%0d want 3 writes=%0d", led_reg, led_writes, w0 + 1); end
  endtask

  initial begin
    repeat (2) @(negedge sys_clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge sys_clk);
    test_reset;
    test_store_led;
    test_load_led;
    test_unmapped;
    test_timeout;
    test_overlap;
    test_back_to_back;
    test_reset_mid_access;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
